// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream sources share one
// registered AXI-Stream output; a granted source keeps the output until its last beat.
module axis_rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_SIZE = 32,
    parameter  int ID_SIZE   = 8,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                           aclk,
    input  logic                           areset_n,
    input  logic [NUM_PORTS-1:0]           s_t_valid,
    output logic [NUM_PORTS-1:0]           s_t_ready,
    input  logic [NUM_PORTS-1:0]           s_t_last,
    input  logic [NUM_PORTS*DATA_SIZE-1:0] s_t_data,
    input  logic [NUM_PORTS*ID_SIZE-1:0]   s_t_id,
    output logic                           m_t_valid,
    input  logic                           m_t_ready,
    output logic                           m_t_last,
    output logic [DATA_SIZE-1:0]           m_t_data,
    output logic [ID_SIZE-1:0]             m_t_id,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [IDX_W:0] NP_W = (IDX_W+1)'(NUM_PORTS);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_W-1:0]       grant_r;
    logic [IDX_W-1:0]       pick_s;
    logic [IDX_W:0]         start_s;
    logic [IDX_W:0]         offset_s;
    logic [IDX_W:0]         sum_s;
    logic [2*NUM_PORTS-1:0] dbl_s;
    logic [NUM_PORTS-1:0]   rot_s;
    logic                   any_valid_s;
    logic                   out_free_s;
    logic                   xfer_s;
    logic                   sel_last_s;
    logic [DATA_SIZE-1:0]   data_arr_s [NUM_PORTS];
    logic [ID_SIZE-1:0]     id_arr_s   [NUM_PORTS];
    logic                   m_valid_r;
    logic                   m_last_r;
    logic [DATA_SIZE-1:0]   m_data_r;
    logic [ID_SIZE-1:0]     m_id_r;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_split
        assign data_arr_s[i] = s_t_data[i*DATA_SIZE +: DATA_SIZE];
        assign id_arr_s[i]   = s_t_id[i*ID_SIZE +: ID_SIZE];
    end

    assign any_valid_s = |s_t_valid;
    assign out_free_s  = ~m_valid_r | m_t_ready;
    assign sel_last_s  = s_t_last[grant_r];
    assign xfer_s      = (state_r == BUSY) & s_t_valid[grant_r] & out_free_s;

    // Round-robin pick: rotate valids so bit 0 is grant+1, take the lowest set bit.
    always_comb begin
        start_s  = {1'b0, grant_r} + {{IDX_W{1'b0}}, 1'b1};
        dbl_s    = {s_t_valid, s_t_valid} >> start_s;
        rot_s    = dbl_s[NUM_PORTS-1:0];
        offset_s = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            offset_s = rot_s[k] ? (IDX_W+1)'(k) : offset_s;
        end
        sum_s  = start_s + offset_s;
        pick_s = (sum_s >= NP_W) ? IDX_W'(sum_s - NP_W) : IDX_W'(sum_s);
    end

    // State register.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a packet ends when its last beat is accepted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (xfer_s && sel_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only when the output register can take a beat.
    always_comb begin
        s_t_ready = '0;
        if (state_r == BUSY) begin
            s_t_ready[grant_r] = out_free_s;
        end else begin
            s_t_ready = '0;
        end
    end

    // Grant pointer: updated only on arbitration, so it doubles as the round-robin pointer.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            grant_r <= IDX_W'(NUM_PORTS - 1);
        end else if ((state_r == IDLE) && any_valid_s) begin
            grant_r <= pick_s;
        end else begin
            grant_r <= grant_r;
        end
    end

    // Output register: load on transfer, otherwise drain when consumer accepts.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
            m_id_r    <= '0;
        end else if (xfer_s) begin
            m_valid_r <= 1'b1;
            m_last_r  <= sel_last_s;
            m_data_r  <= data_arr_s[grant_r];
            m_id_r    <= id_arr_s[grant_r];
        end else if (m_valid_r && m_t_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign m_t_valid = m_valid_r;
    assign m_t_last  = m_last_r;
    assign m_t_data  = m_data_r;
    assign m_t_id    = m_id_r;
    assign grant_idx = grant_r;
    assign busy      = (state_r == BUSY);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter: per-port beat tables feed the
// sources, accepted output beats are captured with their cycle number.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int XW = 2;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b0;
    logic [N-1:0]    s_t_valid = '0;
    logic [N-1:0]    s_t_ready;
    logic [N-1:0]    s_t_last = '0;
    logic [N*DW-1:0] s_t_data = '0;
    logic [N*IW-1:0] s_t_id = '0;
    logic            m_t_valid;
    logic            m_t_ready = 1'b1;
    logic            m_t_last;
    logic [DW-1:0]   m_t_data;
    logic [IW-1:0]   m_t_id;
    logic [XW-1:0]   grant_idx;
    logic            busy;

    always #5 aclk = ~aclk;

    axis_rr_arbiter #(.NUM_PORTS(N), .DATA_SIZE(DW), .ID_SIZE(IW)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_last(s_t_last),
        .s_t_data(s_t_data), .s_t_id(s_t_id),
        .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_last(m_t_last),
        .m_t_data(m_t_data), .m_t_id(m_t_id),
        .grant_idx(grant_idx), .busy(busy)
    );

    typedef struct packed {
        logic [31:0]   cyc;
        logic [IW-1:0] id;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         out_q[$];
    logic [DW-1:0] src_data [N][64];
    logic          src_last [N][64];
    logic [IW-1:0] src_id   [N][64];
    int            src_len  [N];
    int            src_ptr  [N];
    logic          src_en   [N];
    logic          mrdy = 1'b1;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            src_en[i]  = 1'b1;
        end
        out_q.delete();
    endtask

    task automatic add_pkt(input int p, input int nb, input logic [DW-1:0] base, input logic [IW-1:0] id);
        for (int k = 0; k < nb; k++) begin
            src_data[p][src_len[p]] = base + DW'(k);
            src_last[p][src_len[p]] = (k == nb - 1);
            src_id[p][src_len[p]]   = id;
            src_len[p]++;
        end
    endtask

    // One clock: drive from tables, note handshakes before the edge, land at posedge+1.
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && (src_ptr[i] < src_len[i])) begin
                s_t_valid[i]          = 1'b1;
                s_t_last[i]           = src_last[i][src_ptr[i]];
                s_t_data[i*DW +: DW]  = src_data[i][src_ptr[i]];
                s_t_id[i*IW +: IW]    = src_id[i][src_ptr[i]];
            end else begin
                s_t_valid[i]          = 1'b0;
                s_t_last[i]           = 1'b0;
                s_t_data[i*DW +: DW]  = '0;
                s_t_id[i*IW +: IW]    = '0;
            end
        end
        m_t_ready = mrdy;
        #2;
        if (m_t_valid && m_t_ready) out_q.push_back({32'(cyc), m_t_id, m_t_last, m_t_data});
        for (int i = 0; i < N; i++) begin
            if (s_t_valid[i] && s_t_ready[i]) src_ptr[i]++;
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        areset_n  = 1'b0;
        mrdy      = 1'b1;
        m_t_ready = 1'b1;
        s_t_valid = '0;
        s_t_last  = '0;
        clear_src();
        repeat (2) @(posedge aclk);
        #1;
        areset_n = 1'b1;
    endtask

    task automatic run_until_out(input int n, input int budget);
        int t;
        t = 0;
        while ((out_q.size() < n) && (t < budget)) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        areset_n = 1'b0;
        @(posedge aclk);
        #1;
        checks++; if (m_t_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_t_valid); end
        checks++; if (m_t_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b expected 0", m_t_last); end
        checks++; if (m_t_data !== 32'h0) begin errors++; $display("FAIL rst_m_data: got %h expected 0", m_t_data); end
        checks++; if (m_t_id !== 8'h0) begin errors++; $display("FAIL rst_m_id: got %h expected 0", m_t_id); end
        checks++; if (s_t_ready !== 4'b0000) begin errors++; $display("FAIL rst_s_ready: got %b expected 0000", s_t_ready); end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL rst_grant: got %0d expected 3", grant_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        areset_n = 1'b1;
        repeat (3) tick();
        checks++; if ((busy !== 1'b0) || (grant_idx !== 2'd3) || (m_t_valid !== 1'b0)) begin
            errors++; $display("FAIL idle_hold: got busy=%b grant=%0d valid=%b expected 0/3/0", busy, grant_idx, m_t_valid);
        end
    endtask

    task automatic test_single_packet();
        int t0;
        do_reset();
        add_pkt(2, 3, 32'hA0, 8'h21);
        t0 = cyc;
        tick();
        checks++; if ((busy !== 1'b1) || (grant_idx !== 2'd2)) begin
            errors++; $display("FAIL single_arb: got busy=%b grant=%0d expected 1/2", busy, grant_idx);
        end
        run_until_out(3, 20);
        repeat (2) tick();
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", out_q.size()); end
        for (int k = 0; k < 3 && k < out_q.size(); k++) begin
            checks++; if (out_q[k].data !== 32'hA0 + DW'(k)) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, out_q[k].data, 32'hA0 + DW'(k)); end
            checks++; if (out_q[k].last !== (k == 2)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", k, out_q[k].last, (k == 2)); end
            checks++; if (out_q[k].cyc !== 32'(t0 + 2 + k)) begin errors++; $display("FAIL single_cycle[%0d]: got %0d expected %0d", k, out_q[k].cyc, t0 + 2 + k); end
        end
        checks++; if ((grant_idx !== 2'd2) || (busy !== 1'b0) || (m_t_valid !== 1'b0)) begin
            errors++; $display("FAIL single_end: got grant=%0d busy=%b valid=%b expected 2/0/0", grant_idx, busy, m_t_valid);
        end
    endtask

    task automatic test_fairness();
        int pk, p, pkt, b;
        do_reset();
        for (int q = 0; q < 2; q++) begin
            for (int i = 0; i < N; i++) add_pkt(i, 2, DW'(i * 256 + q * 16), IW'(i * 16 + q));
        end
        run_until_out(16, 100);
        checks++; if (out_q.size() != 16) begin errors++; $display("FAIL fair_count: got %0d expected 16", out_q.size()); end
        for (int j = 0; j < 16 && j < out_q.size(); j++) begin
            pk = j / 2; p = pk % N; pkt = pk / N; b = j % 2;
            checks++; if ((out_q[j].data !== DW'(p * 256 + pkt * 16 + b)) || (out_q[j].id !== IW'(p * 16 + pkt)) || (out_q[j].last !== (b == 1))) begin
                errors++; $display("FAIL fair_beat[%0d]: got data=%h id=%h last=%b expected data=%h id=%h last=%b",
                    j, out_q[j].data, out_q[j].id, out_q[j].last, DW'(p * 256 + pkt * 16 + b), IW'(p * 16 + pkt), (b == 1));
            end
            if (j > 0) begin
                checks++; if (out_q[j].cyc - out_q[j-1].cyc !== ((b == 0) ? 32'd2 : 32'd1)) begin
                    errors++; $display("FAIL fair_gap[%0d]: got %0d expected %0d", j, out_q[j].cyc - out_q[j-1].cyc, (b == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_pkt(1, 4, 32'hB0, 8'h11);
        run_until_out(1, 20);
        checks++; if ((m_t_valid !== 1'b1) || (m_t_data !== 32'hB1)) begin
            errors++; $display("FAIL bp_pre: got valid=%b data=%h expected 1/b1", m_t_valid, m_t_data);
        end
        mrdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if ((m_t_valid !== 1'b1) || (m_t_data !== 32'hB1) || (m_t_last !== 1'b0) || (m_t_id !== 8'h11)) begin
                errors++; $display("FAIL bp_stable[%0d]: got valid=%b data=%h last=%b id=%h expected 1/b1/0/11", c, m_t_valid, m_t_data, m_t_last, m_t_id);
            end
            checks++; if (s_t_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, s_t_ready[1]); end
        end
        mrdy = 1'b1;
        run_until_out(4, 30);
        repeat (3) tick();
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", out_q.size()); end
        for (int k = 0; k < 4 && k < out_q.size(); k++) begin
            checks++; if ((out_q[k].data !== 32'hB0 + DW'(k)) || (out_q[k].last !== (k == 3))) begin
                errors++; $display("FAIL bp_beat[%0d]: got data=%h last=%b expected %h/%b", k, out_q[k].data, out_q[k].last, 32'hB0 + DW'(k), (k == 3));
            end
        end
    endtask

    task automatic test_gap_hold();
        int t;
        logic [DW-1:0] exp_d [6];
        exp_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'hD1};
        do_reset();
        add_pkt(3, 2, 32'hD0, 8'h31);
        add_pkt(0, 4, 32'hC0, 8'h01);
        t = 0;
        while ((src_ptr[0] < 2) && (t < 20)) begin
            tick();
            t++;
        end
        src_en[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if ((grant_idx !== 2'd0) || (busy !== 1'b1) || (s_t_ready[3] !== 1'b0)) begin
                errors++; $display("FAIL gap_hold[%0d]: got grant=%0d busy=%b ready3=%b expected 0/1/0", c, grant_idx, busy, s_t_ready[3]);
            end
        end
        src_en[0] = 1'b1;
        run_until_out(6, 40);
        repeat (2) tick();
        checks++; if (out_q.size() != 6) begin errors++; $display("FAIL gap_count: got %0d expected 6", out_q.size()); end
        for (int k = 0; k < 6 && k < out_q.size(); k++) begin
            checks++; if (out_q[k].data !== exp_d[k]) begin errors++; $display("FAIL gap_order[%0d]: got %h expected %h", k, out_q[k].data, exp_d[k]); end
        end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL gap_final_grant: got %0d expected 3", grant_idx); end
    endtask

    task automatic test_async_reset();
        do_reset();
        add_pkt(2, 6, 32'hE0, 8'h22);
        run_until_out(2, 20);
        #3;
        areset_n = 1'b0;
        #1;
        checks++; if ((m_t_valid !== 1'b0) || (busy !== 1'b0) || (grant_idx !== 2'd3) || (s_t_ready !== 4'b0000)) begin
            errors++; $display("FAIL arst_ctrl: got valid=%b busy=%b grant=%0d ready=%b expected 0/0/3/0000", m_t_valid, busy, grant_idx, s_t_ready);
        end
        checks++; if ((m_t_data !== 32'h0) || (m_t_last !== 1'b0) || (m_t_id !== 8'h0)) begin
            errors++; $display("FAIL arst_data: got data=%h last=%b id=%h expected 0/0/0", m_t_data, m_t_last, m_t_id);
        end
        clear_src();
        add_pkt(0, 1, 32'hF0, 8'h05);
        add_pkt(2, 2, 32'hE8, 8'h23);
        @(posedge aclk);
        #1;
        areset_n = 1'b1;
        run_until_out(3, 30);
        repeat (2) tick();
        checks++; if (out_q.size() != 3) begin errors++; $display("FAIL arst_count: got %0d expected 3", out_q.size()); end
        if (out_q.size() == 3) begin
            checks++; if ((out_q[0].data !== 32'hF0) || (out_q[0].last !== 1'b1) || (out_q[0].id !== 8'h05)) begin
                errors++; $display("FAIL arst_first: got data=%h last=%b id=%h expected f0/1/05", out_q[0].data, out_q[0].last, out_q[0].id);
            end
            checks++; if ((out_q[1].data !== 32'hE8) || (out_q[2].data !== 32'hE9) || (out_q[2].last !== 1'b1)) begin
                errors++; $display("FAIL arst_next: got %h %h last=%b expected e8 e9 1", out_q[1].data, out_q[2].data, out_q[2].last);
            end
        end
    endtask

    task automatic test_random();
        int total, t, p, cur;
        int ep[N];
        do_reset();
        total = 0;
        for (int i = 0; i < N; i++) begin
            ep[i] = 0;
            for (int q = 0; q < 8; q++) begin
                t = int'($urandom_range(1, 4));
                add_pkt(i, t, {8'(i), 8'(q), 16'h0000}, IW'(i * 16 + q));
                total += t;
            end
        end
        t = 0;
        while ((out_q.size() < total) && (t < 4000)) begin
            for (int i = 0; i < N; i++) src_en[i] = ($urandom_range(0, 3) != 0);
            mrdy = ($urandom_range(0, 3) != 0);
            tick();
            t++;
        end
        mrdy = 1'b1;
        repeat (3) tick();
        checks++; if (out_q.size() != total) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", out_q.size(), total); end
        cur = -1;
        for (int j = 0; j < out_q.size(); j++) begin
            p = int'(out_q[j].id[7:4]);
            checks++;
            if ((p >= N) || (ep[p] >= src_len[p])) begin
                errors++; $display("FAIL rnd_source[%0d]: got id=%h expected a pending source", j, out_q[j].id);
            end else if ((out_q[j].data !== src_data[p][ep[p]]) || (out_q[j].last !== src_last[p][ep[p]]) || (out_q[j].id !== src_id[p][ep[p]])) begin
                errors++; $display("FAIL rnd_beat[%0d]: got data=%h last=%b id=%h expected data=%h last=%b id=%h",
                    j, out_q[j].data, out_q[j].last, out_q[j].id, src_data[p][ep[p]], src_last[p][ep[p]], src_id[p][ep[p]]);
            end else if ((cur != -1) && (cur != p)) begin
                errors++; $display("FAIL rnd_interleave[%0d]: got port %0d expected port %0d", j, p, cur);
            end
            if (p < N) ep[p]++;
            cur = out_q[j].last ? -1 : p;
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (ep[i] != src_len[i]) begin errors++; $display("FAIL rnd_port_total[%0d]: got %0d expected %0d", i, ep[i], src_len[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_fairness();
        test_backpressure();
        test_gap_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
